serial_work_loader: RTL and testbench

- Downstream consumer of the RS-232 byte receiver. Assembles bursts of received bytes into one fixed-length work packet (midstate + block-data tail) for the hasher array.
- Each packet is PAYLOAD_BYTES payload bytes followed by one XOR checksum byte. A packet ends when the receiver signals end-of-packet (line idle gap).
- A good packet updates the held work word and pulses work_valid. A bad packet is dropped and counted.

---
 rtl/serial_work_loader_if.sv | 25 ++
 rtl/serial_work_loader.sv | 111 +++++++++++
 tb/tb_serial_work_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/serial_work_loader_if.sv
// Byte-stream in / work-packet out bundle between the RS-232 receiver and the loader.
// The slave side is the loader itself; the master side is whoever feeds it bytes.
interface serial_work_loader_if #(
  parameter int PAYLOAD_BYTES = 44,
  parameter int ERR_WIDTH     = 8
);
  logic                       rx_data_ready;
  logic [7:0]                 rx_data;
  logic                       rx_endofpacket;
  logic [PAYLOAD_BYTES*8-1:0] work_data;
  logic                       work_valid;
  logic                       packet_error;
  logic [ERR_WIDTH-1:0]       error_count;
  logic                       busy;

  modport master (
    output rx_data_ready, rx_data, rx_endofpacket,
    input  work_data, work_valid, packet_error, error_count, busy
  );

  modport slave (
    input  rx_data_ready, rx_data, rx_endofpacket,
    output work_data, work_valid, packet_error, error_count, busy
  );
endinterface

// File: rtl/serial_work_loader.sv
// Collects a burst of received bytes into one checksummed work packet for the hashers.
// Good packets replace the held work word; bad ones are dropped and counted.
module serial_work_loader #(
  parameter int PAYLOAD_BYTES = 44,
  parameter int ERR_WIDTH     = 8
) (
  input logic                  clk,
  input logic                  reset,
  serial_work_loader_if.slave  bus
);

  localparam int W  = PAYLOAD_BYTES * 8;
  localparam int CW = $clog2(PAYLOAD_BYTES + 2);
  localparam logic [CW-1:0] PAY_CNT  = CW'(PAYLOAD_BYTES);
  localparam logic [CW-1:0] FULL_CNT = CW'(PAYLOAD_BYTES + 1);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

  state_t               state, nextState;
  logic [CW-1:0]        byteCount;
  logic [W-1:0]         shiftBuf;
  logic [7:0]           csum;
  logic                 csumOk;
  logic [W-1:0]         workData;
  logic                 workValid;
  logic                 packetError;
  logic [ERR_WIDTH-1:0] errorCount;

  logic startPkt, shiftByte, takeCsum, goodPkt, badPkt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // End-of-packet wins over a coincident byte in RECV; bytes beyond the checksum divert to DISCARD.
  always_comb begin
    nextState = state;
    startPkt  = 1'b0;
    shiftByte = 1'b0;
    takeCsum  = 1'b0;
    goodPkt   = 1'b0;
    badPkt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.rx_data_ready) begin
          startPkt  = 1'b1;
          nextState = RECV;
        end
      end
      RECV: begin
        if (bus.rx_endofpacket) begin
          if (byteCount == FULL_CNT && csumOk) goodPkt = 1'b1;
          else                                 badPkt  = 1'b1;
          nextState = IDLE;
        end else if (bus.rx_data_ready) begin
          if (byteCount < PAY_CNT)       shiftByte = 1'b1;
          else if (byteCount == PAY_CNT) takeCsum  = 1'b1;
          else                           nextState = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.rx_endofpacket) begin
          badPkt    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byteCount   <= '0;
      shiftBuf    <= '0;
      csum        <= '0;
      csumOk      <= 1'b0;
      workData    <= '0;
      workValid   <= 1'b0;
      packetError <= 1'b0;
      errorCount  <= '0;
    end else begin
      workValid   <= goodPkt;
      packetError <= badPkt;
      if (startPkt) begin
        shiftBuf  <= {bus.rx_data, shiftBuf[W-1:8]};
        csum      <= bus.rx_data;
        csumOk    <= 1'b0;
        byteCount <= CW'(1);
      end
      if (shiftByte) begin
        shiftBuf  <= {bus.rx_data, shiftBuf[W-1:8]};
        csum      <= csum ^ bus.rx_data;
        byteCount <= byteCount + 1'b1;
      end
      if (takeCsum) begin
        csumOk    <= (bus.rx_data == csum);
        byteCount <= byteCount + 1'b1;
      end
      if (goodPkt) workData <= shiftBuf;
      if (badPkt && errorCount != '1) errorCount <= errorCount + 1'b1;
    end
  end

  assign bus.work_data    = workData;
  assign bus.work_valid   = workValid;
  assign bus.packet_error = packetError;
  assign bus.error_count  = errorCount;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_serial_work_loader.sv
// Directed bench: two loaders (8-bit and 2-bit error counters) share one byte stream.
module tb_serial_work_loader;

  localparam int PB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxReady = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       rxEop = 1'b0;
  int         checks = 0;
  int         errors = 0;

  serial_work_loader_if #(.PAYLOAD_BYTES(PB), .ERR_WIDTH(8)) busA ();
  serial_work_loader_if #(.PAYLOAD_BYTES(PB), .ERR_WIDTH(2)) busB ();

  assign busA.rx_data_ready  = rxReady;
  assign busA.rx_data        = rxData;
  assign busA.rx_endofpacket = rxEop;
  assign busB.rx_data_ready  = rxReady;
  assign busB.rx_data        = rxData;
  assign busB.rx_endofpacket = rxEop;

  serial_work_loader #(.PAYLOAD_BYTES(PB), .ERR_WIDTH(8)) dutA (
    .clk(clk), .reset(reset), .bus(busA.slave)
  );
  serial_work_loader #(.PAYLOAD_BYTES(PB), .ERR_WIDTH(2)) dutB (
    .clk(clk), .reset(reset), .bus(busB.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rxReady = 1'b1;
    rxData  = b;
    @(negedge clk);
    rxReady = 1'b0;
  endtask

  // Returns just after the edge that sampled end-of-packet, when the flags are visible.
  task automatic sendEop();
    @(negedge clk);
    rxEop = 1'b1;
    @(posedge clk);
    #1;
    rxEop = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendGoodPacket();
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h44);
    sendEop();
  endtask

  initial begin
    #12;
    checkOutput("rst_work_data",   64'(busA.work_data),    64'h0);
    checkOutput("rst_work_valid",  64'(busA.work_valid),   64'h0);
    checkOutput("rst_packet_err",  64'(busA.packet_error), 64'h0);
    checkOutput("rst_error_count", 64'(busA.error_count),  64'h0);
    checkOutput("rst_busy",        64'(busA.busy),         64'h0);
    @(negedge clk);
    reset = 1'b0;

    // good packet
    applyStimulus(8'h11);
    checkOutput("s1_busy_mid", 64'(busA.busy), 64'h1);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h44);
    sendEop();
    checkOutput("s1_work_valid", 64'(busA.work_valid),   64'h1);
    checkOutput("s1_packet_err", 64'(busA.packet_error), 64'h0);
    checkOutput("s1_work_data",  64'(busA.work_data),    64'h44332211);
    checkOutput("s1_err_count",  64'(busA.error_count),  64'h0);
    nextCycle();
    checkOutput("s1_valid_drop", 64'(busA.work_valid),   64'h0);
    checkOutput("s1_busy_after", 64'(busA.busy),         64'h0);

    // bad checksum
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h45);
    sendEop();
    checkOutput("s2_packet_err", 64'(busA.packet_error), 64'h1);
    checkOutput("s2_work_valid", 64'(busA.work_valid),   64'h0);
    checkOutput("s2_work_data",  64'(busA.work_data),    64'h44332211);
    checkOutput("s2_err_count",  64'(busA.error_count),  64'h1);
    nextCycle();
    checkOutput("s2_err_drop",   64'(busA.packet_error), 64'h0);

    // short packet
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    sendEop();
    checkOutput("s3_packet_err", 64'(busA.packet_error), 64'h1);
    checkOutput("s3_err_count",  64'(busA.error_count),  64'h2);
    nextCycle();
    checkOutput("s3_busy_after", 64'(busA.busy),         64'h0);

    // overflow: seven bytes, counted once
    for (int i = 0; i < 7; i++) applyStimulus(8'(8'h60 + i));
    checkOutput("s4_busy_discard", 64'(busA.busy), 64'h1);
    sendEop();
    checkOutput("s4_packet_err", 64'(busA.packet_error), 64'h1);
    checkOutput("s4_err_count",  64'(busA.error_count),  64'h3);
    nextCycle();
    checkOutput("s4_err_once",   64'(busA.packet_error), 64'h0);
    checkOutput("s4_err_hold",   64'(busA.error_count),  64'h3);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    applyStimulus(8'hDD);
    applyStimulus(8'h00);
    sendEop();
    checkOutput("s4_work_valid", 64'(busA.work_valid),  64'h1);
    checkOutput("s4_work_data",  64'(busA.work_data),   64'hDDCCBBAA);
    checkOutput("s4_err_count",  64'(busA.error_count), 64'h3);
    checkOutput("s4_errB_count", 64'(busB.error_count), 64'h3);

    // saturation on the 2-bit counter, from a fresh reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'h5A);
      sendEop();
      checkOutput($sformatf("s5_errB_%0d", i), 64'(busB.error_count), 64'((i > 3) ? 3 : i));
      checkOutput($sformatf("s5_errA_%0d", i), 64'(busA.error_count), 64'(i));
      checkOutput($sformatf("s5_perr_%0d", i), 64'(busB.packet_error), 64'h1);
    end

    // reset mid-packet, after loading a known work word
    sendGoodPacket();
    checkOutput("s6_pre_data", 64'(busA.work_data), 64'h44332211);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("s6_rst_work_data", 64'(busA.work_data),    64'h0);
    checkOutput("s6_rst_valid",     64'(busA.work_valid),   64'h0);
    checkOutput("s6_rst_perr",      64'(busA.packet_error), 64'h0);
    checkOutput("s6_rst_err_count", 64'(busA.error_count),  64'h0);
    checkOutput("s6_rst_busy",      64'(busA.busy),         64'h0);
    @(negedge clk);
    reset = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("s6_no_valid", 64'(busA.work_valid),   64'h0);
    checkOutput("s6_no_perr",  64'(busA.packet_error), 64'h0);
    sendGoodPacket();
    checkOutput("s6_work_valid", 64'(busA.work_valid), 64'h1);
    checkOutput("s6_work_data",  64'(busA.work_data),  64'h44332211);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
